// File: rtl/fifo_access_sched_if.sv
// Handshake bundle between producers/consumer, the access scheduler and the shared FIFO.
// The master modport is the scheduler's view of the bundle.
interface fifo_access_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic               rd_req;
  logic               rd_valid;
  logic               fifo_wn;
  logic               fifo_rn;
  logic [DW-1:0]      fifo_datain;
  logic               fifo_full;
  logic               fifo_empty;

  modport master (
    input  req, wdata, rd_req, fifo_full, fifo_empty,
    output gnt, rd_valid, fifo_wn, fifo_rn, fifo_datain
  );

  modport slave (
    output req, wdata, rd_req, fifo_full, fifo_empty,
    input  gnt, rd_valid, fifo_wn, fifo_rn, fifo_datain
  );
endinterface

// File: rtl/fifo_access_sched.sv
// Round-robin write arbiter plus single read consumer for the shared 8-deep FIFO.
// Reads win once WR_BURST consecutive writes have happened while a read was waiting.
module fifo_access_sched #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int WR_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_access_sched_if.master  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [3:0]    wr_streak;
  logic          rd_valid_q;

  logic          wr_ok;
  logic          rd_ok;
  logic          force_rd;
  logic          do_rd;
  logic          do_wr;
  logic          found;
  logic [PW-1:0] winner;
  logic [PW-1:0] idx;

  // Scan from rr_ptr upward, wrapping at NREQ; first set request wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    wr_ok    = (|bus.req) && !bus.fifo_full;
    rd_ok    = bus.rd_req && !bus.fifo_empty;
    force_rd = rd_ok && (wr_streak == 4'(WR_BURST));
    // The FIFO drops a read issued together with a write, so the two are exclusive.
    do_rd    = rst && rd_ok && (!wr_ok || force_rd);
    do_wr    = rst && wr_ok && !do_rd;
  end

  always_comb begin
    bus.gnt         = '0;
    bus.fifo_datain = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (do_wr && (winner == PW'(i))) begin
        bus.gnt[i]      = 1'b1;
        bus.fifo_datain = bus.wdata[i*DW +: DW];
      end
    end
    bus.fifo_wn  = do_wr;
    bus.fifo_rn  = do_rd;
    bus.rd_valid = rd_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr     <= '0;
      wr_streak  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_rd;
      if (do_wr) begin
        rr_ptr <= PW'((int'(winner) + 1) % NREQ);
      end
      if (do_wr && rd_ok) begin
        if (wr_streak != 4'(WR_BURST)) begin
          wr_streak <= wr_streak + 4'd1;
        end
      end else if (do_rd || !rd_ok) begin
        wr_streak <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_access_sched.sv
// Bench for fifo_access_sched: directed scenarios then randomized traffic, checked
// against a rule-level reference model and a data scoreboard around a FIFO model.
module tb_fifo_access_sched;
  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int WR_BURST = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fifo_access_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_access_sched #(.NREQ(NREQ), .DW(DW), .WR_BURST(WR_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO stand-in: reports full at 7 entries, drops a read that coincides with a write.
  logic [DW-1:0] fq[$];
  int            cnt = 0;
  logic [DW-1:0] dout = '0;

  always @(posedge clk) begin
    if (!rst) begin
      fq.delete();
      cnt  <= 0;
      dout <= '0;
    end else if (bus.fifo_wn && fq.size() < 8) begin
      fq.push_back(bus.fifo_datain);
      cnt <= cnt + 1;
    end else if (bus.fifo_rn && fq.size() > 0) begin
      dout <= fq.pop_front();
      cnt  <= cnt - 1;
    end
  end

  assign bus.fifo_full  = (cnt >= 7);
  assign bus.fifo_empty = (cnt == 0);

  // Reference model state
  int            m_ptr    = 0;
  int            m_streak = 0;
  logic          m_rdv    = 1'b0;
  logic [DW-1:0] m_rd_data = '0;
  logic [DW-1:0] sb[$];
  int            last_win = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model at the edge.
  task automatic cyc(input string tag);
    logic            wr_ok, rd_ok, drd, dwr;
    int              win;
    logic [NREQ-1:0] rq;
    logic [NREQ-1:0] eg;
    logic [DW-1:0]   ed;
    #2;
    rq    = bus.req;
    wr_ok = (rq != '0) && !bus.fifo_full;
    rd_ok = bus.rd_req && !bus.fifo_empty;
    drd   = rst && rd_ok && (!wr_ok || (m_streak == WR_BURST));
    dwr   = rst && wr_ok && !drd;
    win   = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (win < 0 && ((rq >> j) & 1) == 1) win = j;
    end
    eg = '0;
    ed = '0;
    if (dwr) begin
      eg = NREQ'(1) << win;
      ed = DW'(bus.wdata >> (win * DW));
    end
    chk({tag, ".gnt"},    32'(bus.gnt),         32'(eg));
    chk({tag, ".wn"},     32'(bus.fifo_wn),     32'(dwr));
    chk({tag, ".rn"},     32'(bus.fifo_rn),     32'(drd));
    chk({tag, ".datain"}, 32'(bus.fifo_datain), 32'(ed));
    chk({tag, ".rdv"},    32'(bus.rd_valid),    32'(m_rdv));
    if (m_rdv) chk({tag, ".rdata"}, 32'(dout), 32'(m_rd_data));
    @(posedge clk);
    if (!rst) begin
      m_ptr    = 0;
      m_streak = 0;
      m_rdv    = 1'b0;
      sb.delete();
      last_win = -1;
    end else begin
      m_rdv = drd;
      if (drd && sb.size() > 0) m_rd_data = sb.pop_front();
      if (dwr) begin
        sb.push_back(ed);
        m_ptr = (win + 1) % NREQ;
      end
      if (dwr && rd_ok) m_streak = (m_streak < WR_BURST) ? m_streak + 1 : WR_BURST;
      else if (drd || !rd_ok) m_streak = 0;
      last_win = dwr ? win : -1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc("rst");
    rst = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] rr_seq [7];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    rst        = 1'b0;
    bus.req    = '0;
    bus.wdata  = '0;
    bus.rd_req = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with everything requesting
    bus.req    = 4'b1111;
    bus.wdata  = 32'h44332211;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("reset");
    rst = 1'b1;
    #2 chk("reset_release_gnt", 32'(bus.gnt), 32'h1);
    cyc("release");

    // Round-robin until the FIFO reports full
    do_reset();
    bus.rd_req = 1'b0;
    bus.req    = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      #2 chk("rr_seq", 32'(bus.gnt), 32'(rr_seq[i]));
      cyc("rr");
    end
    for (int i = 0; i < 3; i++) begin
      #2 chk("full_gnt", 32'(bus.gnt | NREQ'(bus.fifo_wn)), 32'h0);
      cyc("full");
    end

    // Starvation bound with one entry preloaded
    do_reset();
    bus.req    = 4'b0001;
    bus.rd_req = 1'b0;
    cyc("preload");
    bus.req    = 4'b1111;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 30; i++) cyc("starve");

    // Data routing through requester 2
    do_reset();
    bus.req    = 4'b0100;
    bus.wdata  = 32'h00A50000;
    #2 chk("route_datain", 32'(bus.fifo_datain), 32'hA5);
    cyc("route_wr");
    bus.req    = '0;
    bus.rd_req = 1'b1;
    cyc("route_rd");
    chk("route_dout", 32'(dout), 32'hA5);
    cyc("route_rdv");

    // Empty FIFO with a pending read request
    do_reset();
    bus.req    = '0;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 10; i++) cyc("empty");
    bus.req    = 4'b1000;
    bus.wdata  = 32'h3C000000;
    bus.rd_req = 1'b0;
    cyc("single_wr");
    bus.req    = '0;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("single_rd");

    // Reset in the third cycle of a write burst
    do_reset();
    bus.req    = 4'b1111;
    bus.rd_req = 1'b0;
    cyc("burst1");
    cyc("burst2");
    rst = 1'b0;
    #2 chk("midrst_wn", 32'(bus.fifo_wn), 32'h0);
    cyc("midrst");
    rst = 1'b1;
    #2 chk("midrst_restart", 32'(bus.gnt), 32'h1);
    cyc("restart");

    // Randomized traffic following the hold-until-grant protocol
    do_reset();
    bus.req = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_win == i) begin
          bus.req[i] = 1'($urandom_range(0, 1));
          bus.wdata[i*DW +: DW] = DW'($urandom);
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.req[i] = 1'b1;
          bus.wdata[i*DW +: DW] = DW'($urandom);
        end
      end
      bus.rd_req = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) != 0);
      cyc("rand");
      rst = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
